// File: rtl/jstep_sequencer.sv
// Run-control sequencer: generates the four-phase computer clock and one-hot step
// vector, and decides between free-run, single-instruction step and stop.
module jstep_sequencer #(
    parameter int unsigned NSTEPS = 6,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_req,
    input  logic              halt,
    output logic              wclk,
    output logic              wclkd,
    output logic              wclke,
    output logic              wclks,
    output logic [NSTEPS-1:0] bos,
    output logic              busy,
    output logic              halted,
    output logic [CNTW-1:0]   icount
);

    typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;
    typedef enum logic [1:0] {PhP0, PhP1, PhP2, PhP3} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [NSTEPS-1:0] bos_q, bos_d;
    logic [CNTW-1:0]   icount_q, icount_d;
    logic              halted_q, halted_d;
    logic              latch_q, latch_d;
    logic              wclk_q, wclk_d;
    logic              wclkd_q, wclkd_d;
    logic              wclke_q, wclks_q;
    logic              busy_q, busy_d;
    logic              last_step;
    logic              stop_halt;

    assign last_step = bos_q[NSTEPS-1];
    // A halt pulse on the boundary cycle itself still stops this instruction.
    assign stop_halt = latch_q | halt;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bos_d    = bos_q;
        icount_d = icount_q;
        halted_d = halted_q;
        latch_d  = latch_q;
        unique case (state_q)
            StIdle: begin
                phase_d = PhP0;
                if (step_req) begin
                    state_d  = StStep;
                    halted_d = 1'b0;
                end else if (run && !halted_q) begin
                    state_d = StRun;
                end
            end
            StRun, StStep: begin
                latch_d = latch_q | halt;
                phase_d = phase_e'(phase_q + 2'd1);
                if (phase_q == PhP3) begin
                    bos_d = {bos_q[NSTEPS-2:0], bos_q[NSTEPS-1]};
                    if (last_step) begin
                        icount_d = icount_q + CNTW'(1);
                        latch_d  = 1'b0;
                        if (stop_halt) begin
                            state_d  = StIdle;
                            halted_d = 1'b1;
                        end else if (state_q == StStep || !run) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = PhP0;
            end
        endcase
    end

    // Outputs are registered from the next-cycle phase so they change on the same edge.
    always_comb begin
        busy_d  = (state_d != StIdle);
        wclk_d  = busy_d && (phase_d == PhP0 || phase_d == PhP1);
        wclkd_d = busy_d && (phase_d == PhP1 || phase_d == PhP2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= PhP0;
            bos_q    <= NSTEPS'(1);
            icount_q <= '0;
            halted_q <= 1'b0;
            latch_q  <= 1'b0;
            wclk_q   <= 1'b0;
            wclkd_q  <= 1'b0;
            wclke_q  <= 1'b0;
            wclks_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bos_q    <= bos_d;
            icount_q <= icount_d;
            halted_q <= halted_d;
            latch_q  <= latch_d;
            wclk_q   <= wclk_d;
            wclkd_q  <= wclkd_d;
            wclke_q  <= wclk_d | wclkd_d;
            wclks_q  <= wclk_d & wclkd_d;
            busy_q   <= busy_d;
        end
    end

    assign wclk   = wclk_q;
    assign wclkd  = wclkd_q;
    assign wclke  = wclke_q;
    assign wclks  = wclks_q;
    assign bos    = bos_q;
    assign busy   = busy_q;
    assign halted = halted_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_jstep_sequencer.sv
// Bench for jstep_sequencer: directed scenarios plus random control traffic, checked
// each cycle against an instruction-time model; a second instance checks icount wrap.
module tb_jstep_sequencer;
    localparam int NSTEPS = 6;
    localparam int CNTW   = 16;
    localparam int ILEN   = 4 * NSTEPS;

    logic clk = 1'b0;
    logic reset = 1'b1, run = 1'b0, step_req = 1'b0, halt = 1'b0;
    logic wclk, wclkd, wclke, wclks, busy, halted;
    logic [NSTEPS-1:0] bos;
    logic [CNTW-1:0]   icount;
    logic w2_wclk, w2_wclkd, w2_wclke, w2_wclks, w2_busy, w2_halted;
    logic [NSTEPS-1:0] w2_bos;
    logic [1:0]        w2_icount;

    always #5 clk = ~clk;

    jstep_sequencer #(.NSTEPS(NSTEPS), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .halt(halt),
        .wclk(wclk), .wclkd(wclkd), .wclke(wclke), .wclks(wclks), .bos(bos),
        .busy(busy), .halted(halted), .icount(icount)
    );

    jstep_sequencer #(.NSTEPS(NSTEPS), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .halt(halt),
        .wclk(w2_wclk), .wclkd(w2_wclkd), .wclke(w2_wclke), .wclks(w2_wclks), .bos(w2_bos),
        .busy(w2_busy), .halted(w2_halted), .icount(w2_icount)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: time within the current instruction plus run mode.
    bit          m_busy, m_single, m_halted, m_latch;
    int          m_t;
    int unsigned m_icnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_single = 0; m_halted = 0; m_latch = 0; m_t = 0; m_icnt = 0;
        end else if (!m_busy) begin
            if (step_req) begin
                m_busy = 1; m_single = 1; m_halted = 0; m_t = 0;
            end else if (run && !m_halted) begin
                m_busy = 1; m_single = 0; m_t = 0;
            end
        end else begin
            if (halt) m_latch = 1;
            if (m_t == ILEN - 1) begin
                m_icnt = (m_icnt + 1) % (1 << CNTW);
                m_t = 0;
                if (m_latch) begin
                    m_halted = 1; m_latch = 0; m_busy = 0;
                end else if (m_single || !run) begin
                    m_busy = 0;
                end
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_all();
        int ph;
        logic [NSTEPS-1:0] ebos;
        logic ewclk, ewclkd;
        ph     = m_t % 4;
        ewclk  = m_busy && (ph < 2);
        ewclkd = m_busy && (ph == 1 || ph == 2);
        ebos   = '0;
        ebos[m_busy ? m_t / 4 : 0] = 1'b1;
        check_eq("wclk", 32'(wclk), 32'(ewclk));
        check_eq("wclkd", 32'(wclkd), 32'(ewclkd));
        check_eq("wclke", 32'(wclke), 32'(ewclk | ewclkd));
        check_eq("wclks", 32'(wclks), 32'(ewclk & ewclkd));
        check_eq("bos", 32'(bos), 32'(ebos));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("icount", 32'(icount), m_icnt);
        check_eq("icount_w2", 32'(w2_icount), m_icnt % 4);
        check_eq("busy_w2", 32'(w2_busy), 32'(m_busy));
    endtask

    task automatic cyc(input logic r, input logic s, input logic h, input logic rs);
        run = r; step_req = s; halt = h; reset = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Reset held with run=1, then free-run two instructions.
        repeat (3) cyc(1, 0, 0, 1);
        check_eq("rst_bos", 32'(bos), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        cyc(1, 0, 0, 0);
        check_eq("start_wclk", 32'(wclk), 32'd1);
        repeat (47) cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        check_eq("freerun_icount", 32'(icount), 32'd2);
        check_eq("freerun_bos", 32'(bos), 32'd1);

        // Single step with an ignored second request.
        cyc(0, 1, 0, 0);
        for (int i = 1; i < 30; i++) cyc(0, (i == 10), 0, 0);
        check_eq("sstep_icount", 32'(icount), 32'd3);

        // Halt during instruction 2; run stays high but sequencer parks.
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 80; i++) cyc(1, 0, (i == ILEN + 13), 0);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_icount", 32'(icount), 32'd2);
        check_eq("halt_busy", 32'(busy), 32'd0);
        cyc(1, 1, 0, 0);
        check_eq("halt_clear", 32'(halted), 32'd0);
        repeat (60) cyc(1, 0, 0, 0);

        // Reset while wclks is high mid-instruction.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (13) cyc(0, 0, 0, 0);
        check_eq("mid_wclks_pre", 32'(wclks), 32'd1);
        cyc(0, 0, 0, 1);
        check_eq("mid_wclks", 32'(wclks), 32'd0);
        check_eq("mid_icount", 32'(icount), 32'd0);

        // Five instructions: narrow counter wraps 1,2,3,0,1.
        cyc(0, 0, 0, 0);
        repeat (5 * ILEN) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        check_eq("wrap_icount2", 32'(w2_icount), 32'd1);

        // Random control traffic.
        begin
            logic r;
            r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(39) == 0) r = ~r;
                cyc(r, ($urandom_range(29) == 0), ($urandom_range(49) == 0),
                    ($urandom_range(399) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
